// File: rtl/sd_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sd_spi_arbiter
//  Description : Shares one SD SPI command/response shifter and its chip
//                select between three requesters (0 = init, 1 = write,
//                2 = read). One owner at a time; the grant is held until the
//                owner releases, and every release is followed by a
//                chip-select-high gap of GAP_CYCLES SCLK rising edges.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                rising_edge_sclk    - one-clk pulse per SCLK rising edge
//                req / done          - per-requester request / release pulse
//                cmd_in, load_cmd_in, shift_cmd_in, shift_read_in, cs_in
//                                    - per-requester shifter controls
//                grant               - one-hot registered grant
//                command, load_command, shift_command, shift_read, sd_CS
//                                    - controls of the current owner
//                busy                - arbiter not idle
//                timeout_err         - one-clk pulse on watchdog release
//  Options     : SD_ARB_TIMEOUT_EN   - enables the ownership watchdog
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_arbiter #(
    parameter int CMD_W          = 48,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rising_edge_sclk,
    input  logic [2:0]         req,
    input  logic [2:0]         done,
    input  logic [3*CMD_W-1:0] cmd_in,
    input  logic [2:0]         load_cmd_in,
    input  logic [2:0]         shift_cmd_in,
    input  logic [2:0]         shift_read_in,
    input  logic [2:0]         cs_in,
    output logic [2:0]         grant,
    output logic [CMD_W-1:0]   command,
    output logic               load_command,
    output logic               shift_command,
    output logic               shift_read,
    output logic               sd_CS,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] c_gap_last = 8'(GAP_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_grant, w_grant_nxt;
    logic [7:0] r_gap_cnt, w_gap_cnt_nxt;
    // 0: write was served last (read wins a tie), 1: read was served last
    logic       r_rr_last, w_rr_last_nxt;

    logic [2:0] w_req_elig;
    logic [2:0] w_winner;
    logic       w_release;
    logic       w_timeout;
    logic [1:0] w_sel;
    logic       w_owner_active;

    // Owner lets go either by pulsing done or by dropping its request
    assign w_release = (|(done & r_grant)) | ~(|(req & r_grant));

`ifdef SD_ARB_TIMEOUT_EN
    localparam int                c_wd_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYCLES - 1);

    logic [c_wd_w-1:0] r_wd_cnt, w_wd_cnt_nxt;
    logic [2:0]        r_inelig, w_inelig_nxt;
    logic              r_timeout_err;
    logic              w_owner_strobe;

    assign w_owner_strobe = |((load_cmd_in | shift_cmd_in | shift_read_in) & r_grant);

    // Fires on the SCLK edge that would bring the idle count to TIMEOUT_CYCLES
    assign w_timeout = (r_state == ST_OWN) && !w_release && !w_owner_strobe &&
                       rising_edge_sclk && (r_wd_cnt == c_wd_last);

    // A timed-out requester stays locked out until it drops its request
    assign w_req_elig = req & ~r_inelig;

    always_comb begin
        w_wd_cnt_nxt = r_wd_cnt;
        if ((r_state != ST_OWN) || w_owner_strobe || w_timeout) begin
            w_wd_cnt_nxt = '0;
        end else if (rising_edge_sclk) begin
            w_wd_cnt_nxt = r_wd_cnt + 1'b1;
        end
        w_inelig_nxt = (r_inelig | (w_timeout ? r_grant : 3'b000)) & req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt      <= '0;
            r_inelig      <= 3'b000;
            r_timeout_err <= 1'b0;
        end else begin
            r_wd_cnt      <= w_wd_cnt_nxt;
            r_inelig      <= w_inelig_nxt;
            r_timeout_err <= w_timeout;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
    assign w_req_elig   = req;
    assign w_timeout    = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // Init has absolute priority; write/read alternate on a tie
    always_comb begin
        w_winner = 3'b000;
        if (w_req_elig[0]) begin
            w_winner = 3'b001;
        end else if (w_req_elig[1] && w_req_elig[2]) begin
            w_winner = r_rr_last ? 3'b010 : 3'b100;
        end else if (w_req_elig[1]) begin
            w_winner = 3'b010;
        end else if (w_req_elig[2]) begin
            w_winner = 3'b100;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_gap_cnt_nxt = r_gap_cnt;
        w_rr_last_nxt = r_rr_last;
        case (r_state)
            ST_IDLE: begin
                if (w_winner != 3'b000) begin
                    w_state_nxt = ST_OWN;
                    w_grant_nxt = w_winner;
                    if (w_winner[1]) begin
                        w_rr_last_nxt = 1'b0;
                    end else if (w_winner[2]) begin
                        w_rr_last_nxt = 1'b1;
                    end
                end
            end
            ST_OWN: begin
                if (w_release || w_timeout) begin
                    w_state_nxt   = ST_GAP;
                    w_grant_nxt   = 3'b000;
                    w_gap_cnt_nxt = 8'd0;
                end
            end
            ST_GAP: begin
                if (rising_edge_sclk) begin
                    if (r_gap_cnt == c_gap_last) begin
                        w_state_nxt   = ST_IDLE;
                        w_gap_cnt_nxt = 8'd0;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_grant_nxt   = 3'b000;
                w_gap_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= 3'b000;
            r_gap_cnt <= 8'd0;
            r_rr_last <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_rr_last <= w_rr_last_nxt;
        end
    end

    // Encode the one-hot grant to an index for the output mux
    always_comb begin
        w_sel = 2'd0;
        if (r_grant[1]) begin
            w_sel = 2'd1;
        end
        if (r_grant[2]) begin
            w_sel = 2'd2;
        end
    end

    assign w_owner_active = (r_state == ST_OWN) && (r_grant != 3'b000);

    assign grant         = r_grant;
    assign command       = w_owner_active ? cmd_in[w_sel*CMD_W +: CMD_W] : '0;
    assign load_command  = w_owner_active & load_cmd_in[w_sel];
    assign shift_command = w_owner_active & shift_cmd_in[w_sel];
    assign shift_read    = w_owner_active & shift_read_in[w_sel];
    assign sd_CS         = w_owner_active ? cs_in[w_sel] : 1'b1;
    assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_spi_arbiter
//  Description : Self-checking bench for sd_spi_arbiter. Cycle records carry
//                the inputs and the expected grant/busy/timeout; a small
//                model derives the expected muxed outputs, which are queued
//                when a record is driven and compared after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_spi_arbiter;

    localparam int CMD_W          = 48;
    localparam int GAP_CYCLES     = 8;
    localparam int TIMEOUT_CYCLES = 16;

    localparam logic [CMD_W-1:0] C_CMD0 = 48'h400000000095;
    localparam logic [CMD_W-1:0] C_CMD1 = 48'h580000001234;
    localparam logic [CMD_W-1:0] C_CMD2 = 48'h510000000095;

    logic               clk = 1'b0;
    logic               rst;
    logic               rising_edge_sclk;
    logic [2:0]         req, done, load_cmd_in, shift_cmd_in, shift_read_in, cs_in;
    logic [3*CMD_W-1:0] cmd_in;
    logic [2:0]         grant;
    logic [CMD_W-1:0]   command;
    logic               load_command, shift_command, shift_read, sd_CS, busy, timeout_err;

    logic [CMD_W-1:0]   cmds [3];

    assign cmd_in = {C_CMD2, C_CMD1, C_CMD0};

    always #5 clk = ~clk;

    sd_spi_arbiter #(
        .CMD_W          (CMD_W),
        .GAP_CYCLES     (GAP_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rising_edge_sclk (rising_edge_sclk),
        .req              (req),
        .done             (done),
        .cmd_in           (cmd_in),
        .load_cmd_in      (load_cmd_in),
        .shift_cmd_in     (shift_cmd_in),
        .shift_read_in    (shift_read_in),
        .cs_in            (cs_in),
        .grant            (grant),
        .command          (command),
        .load_command     (load_command),
        .shift_command    (shift_command),
        .shift_read       (shift_read),
        .sd_CS            (sd_CS),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] req, done, ld, sc, sr, csn;
        logic       sclk;
        logic [2:0] egrant;
        logic       ebusy, eterr;
    } vec_t;

    typedef struct {
        logic [2:0]       grant;
        logic [CMD_W-1:0] command;
        logic             load, shc, shr, cs, busy, terr;
    } exp_t;

    vec_t vecs [$];
    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input string name, input logic r, input logic [2:0] rq,
                       input logic [2:0] dn, input logic [2:0] ld, input logic [2:0] sc,
                       input logic [2:0] sr, input logic [2:0] csn, input logic sk,
                       input logic [2:0] eg, input logic eb, input logic et);
        vec_t v;
        v.name = name; v.rst = r; v.req = rq; v.done = dn; v.ld = ld; v.sc = sc;
        v.sr = sr; v.csn = csn; v.sclk = sk; v.egrant = eg; v.ebusy = eb; v.eterr = et;
        vecs.push_back(v);
    endtask

    // GAP_CYCLES sclk pulses; busy drops on the edge of the last pulse
    task automatic add_gap(input string name, input logic [2:0] rq);
        for (int k = 0; k < GAP_CYCLES; k++) begin
            add(name, 1'b0, rq, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 1'b1,
                3'b000, (k < GAP_CYCLES - 1) ? 1'b1 : 1'b0, 1'b0);
        end
    endtask

    // Expected shifter-side outputs given the expected owner
    function automatic exp_t model(input vec_t v);
        exp_t e;
        int   idx;
        e.grant   = v.egrant;
        e.busy    = v.ebusy;
        e.terr    = v.eterr;
        e.command = '0;
        e.load    = 1'b0;
        e.shc     = 1'b0;
        e.shr     = 1'b0;
        e.cs      = 1'b1;
        if (v.egrant != 3'b000) begin
            idx       = v.egrant[0] ? 0 : (v.egrant[1] ? 1 : 2);
            e.command = cmds[idx];
            e.load    = v.ld[idx];
            e.shc     = v.sc[idx];
            e.shr     = v.sr[idx];
            e.cs      = v.csn[idx];
        end
        return e;
    endfunction

    task automatic check_out(input string name);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb_q.pop_front();
        if (grant !== e.grant || command !== e.command || load_command !== e.load ||
            shift_command !== e.shc || shift_read !== e.shr || sd_CS !== e.cs ||
            busy !== e.busy || timeout_err !== e.terr) begin
            n_fail++;
            $display("FAIL %s: got grant=%b cmd=%h ld=%b sc=%b sr=%b cs=%b busy=%b terr=%b; expected grant=%b cmd=%h ld=%b sc=%b sr=%b cs=%b busy=%b terr=%b",
                     name, grant, command, load_command, shift_command, shift_read, sd_CS,
                     busy, timeout_err, e.grant, e.command, e.load, e.shc, e.shr, e.cs,
                     e.busy, e.terr);
        end
    endtask

    task automatic run_vecs();
        vec_t v;
        while (vecs.size() > 0) begin
            v                = vecs.pop_front();
            rst              = v.rst;
            req              = v.req;
            done             = v.done;
            load_cmd_in      = v.ld;
            shift_cmd_in     = v.sc;
            shift_read_in    = v.sr;
            cs_in            = v.csn;
            rising_edge_sclk = v.sclk;
            sb_q.push_back(model(v));
            @(posedge clk);
            #1;
            check_out(v.name);
        end
    endtask

    initial begin
        cmds[0] = C_CMD0;
        cmds[1] = C_CMD1;
        cmds[2] = C_CMD2;

        // Reset, lone read, release with a concurrent write request
        add("reset_0",          1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 0, 3'b000, 0, 0);
        add("reset_1",          1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 0, 3'b000, 0, 0);
        add("lone_read_grant",  0, 3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 3'b011, 0, 3'b100, 1, 0);
        add("read_shift",       0, 3'b100, 3'b000, 3'b000, 3'b100, 3'b100, 3'b011, 0, 3'b100, 1, 0);
        add("read_done_release",0, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000, 3'b011, 0, 3'b000, 1, 0);
        add_gap("gap_write_waits", 3'b010);
        add("write_grant",      0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 0, 3'b010, 1, 0);
        // Non-owner strobes, CS and done must be ignored
        add("isolation",        0, 3'b110, 3'b100, 3'b100, 3'b100, 3'b100, 3'b011, 0, 3'b010, 1, 0);
        add("write_shift",      0, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 3'b101, 0, 3'b010, 1, 0);
        add("write_release",    0, 3'b111, 3'b010, 3'b000, 3'b000, 3'b000, 3'b111, 0, 3'b000, 1, 0);
        add_gap("gap_no_early_grant", 3'b111);
        add("init_priority",    0, 3'b111, 3'b000, 3'b001, 3'b000, 3'b000, 3'b110, 0, 3'b001, 1, 0);
        add("init_release",     0, 3'b110, 3'b001, 3'b000, 3'b000, 3'b000, 3'b111, 0, 3'b000, 1, 0);
        add_gap("gap_after_init", 3'b110);
        add("rr_read_wins",     0, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 0, 3'b100, 1, 0);
        add("read_release",     0, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000, 3'b111, 0, 3'b000, 1, 0);
        add_gap("gap_after_read", 3'b110);
        add("rr_write_next",    0, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 0, 3'b010, 1, 0);
        add("write_hold",       0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b101, 0, 3'b010, 1, 0);
        add("write_release_2",  0, 3'b100, 3'b010, 3'b000, 3'b000, 3'b000, 3'b111, 0, 3'b000, 1, 0);
        add_gap("gap_before_read", 3'b100);
        add("single_read",      0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 0, 3'b100, 1, 0);
        run_vecs();

        // Reset mid-ownership while CS is low; round-robin must restart
        add("reset_mid_own",    1, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 0, 3'b000, 0, 0);
        add("rr_after_reset",   0, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 0, 3'b100, 1, 0);
        // Owner dropping its request releases without done
        add("req_drop_release", 0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 0, 3'b000, 1, 0);
        add("reset_again",      1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 0, 3'b000, 0, 0);
        add("single_write",     0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 0, 3'b010, 1, 0);
        add("reset_pre_wd",     1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 0, 3'b000, 0, 0);
        run_vecs();

`ifdef SD_ARB_TIMEOUT_EN
        // Stalled owner is forced off after TIMEOUT_CYCLES idle sclk edges
        add("wd_grant",         0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 0, 3'b100, 1, 0);
        for (int k = 0; k < TIMEOUT_CYCLES; k++) begin
            add("wd_stall", 0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 1,
                (k < TIMEOUT_CYCLES - 1) ? 3'b100 : 3'b000, 1,
                (k == TIMEOUT_CYCLES - 1) ? 1'b1 : 1'b0);
        end
        add("wd_pulse_once",    0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 0, 3'b000, 1, 0);
        add_gap("wd_gap", 3'b100);
        add("wd_not_regranted", 0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 0, 3'b000, 0, 0);
        add("wd_req_low",       0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 0, 3'b000, 0, 0);
        add("wd_regrant",       0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 0, 3'b100, 1, 0);
`else
        // Without the watchdog an idle owner keeps the grant indefinitely
        add("hold_grant",       0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 0, 3'b100, 1, 0);
        for (int k = 0; k < TIMEOUT_CYCLES + 4; k++) begin
            add("hold_no_watchdog", 0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 1,
                3'b100, 1, 0);
        end
`endif
        run_vecs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
